// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio
// Desc     : Zero-latency data RAM with memory-mapped 8N1 UART transmitter and
//            optional timer/compare interrupt (define DMEM_MMIO_TIMER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
    parameter int DEPTH_WORDS = 64,
    parameter int CLK_DIV     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int DW = $clog2(CLK_DIV);

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] c_UART_DATA = 30'h3FFF_C000;
    localparam logic [29:0] c_UART_STAT = 30'h3FFF_C001;
    localparam logic [29:0] c_TMR_COUNT = 30'h3FFF_C002;
    localparam logic [29:0] c_TMR_CMP   = 30'h3FFF_C003;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] w_ram_idx;
    logic          w_is_ram;
    logic          w_sel_udata;
    logic          w_sel_ustat;
    logic          w_unused;

    uart_state_t   r_state, w_state_next;
    logic [DW-1:0] r_div, w_div_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_byte, w_byte_next;
    logic          r_overrun, w_overrun_next;
    logic          w_busy;
    logic          w_div_end;
    logic          w_uart_wr;

    assign w_is_ram    = (addr[31:28] == 4'h0);
    assign w_ram_idx   = addr[AW+1:2];
    assign w_sel_udata = (addr[31:2] == c_UART_DATA);
    assign w_sel_ustat = (addr[31:2] == c_UART_STAT);
    assign w_unused    = ^{addr[1:0], wdata};

    // RAM is deliberately outside reset so contents survive a core reset
    always_ff @(posedge clk) begin
        if (mem_write && w_is_ram) begin
            r_mem[w_ram_idx] <= wdata;
        end
    end

    assign w_busy    = (r_state != S_IDLE);
    assign w_div_end = (r_div == DW'(CLK_DIV - 1));
    assign w_uart_wr = mem_write && w_sel_udata;

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        case (r_state)
            S_IDLE: begin
                if (w_uart_wr) begin
                    w_state_next = S_START;
                    w_div_next   = '0;
                    w_byte_next  = wdata[7:0];
                end
            end
            S_START: begin
                if (w_div_end) begin
                    w_state_next = S_DATA;
                    w_div_next   = '0;
                    w_bit_next   = 3'd0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_DATA: begin
                if (w_div_end) begin
                    w_div_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_STOP: begin
                if (w_div_end) begin
                    w_state_next = S_IDLE;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // A dropped byte must stay flagged even if STAT is cleared this cycle
        w_overrun_next = r_overrun;
        if (w_uart_wr && w_busy) begin
            w_overrun_next = 1'b1;
        end else if (mem_write && w_sel_ustat) begin
            w_overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= 3'd0;
            r_byte    <= 8'd0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div     <= w_div_next;
            r_bit     <= w_bit_next;
            r_byte    <= w_byte_next;
            r_overrun <= w_overrun_next;
        end
    end

    always_comb begin
        case (r_state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = r_byte[r_bit];
            default: uart_tx = 1'b1;
        endcase
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_irq;
    logic        w_sel_tcount;
    logic        w_sel_tcmp;

    assign w_sel_tcount = (addr[31:2] == c_TMR_COUNT);
    assign w_sel_tcmp   = (addr[31:2] == c_TMR_CMP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 32'd0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_irq   <= 1'b0;
        end else begin
            r_count <= (mem_write && w_sel_tcount) ? wdata : r_count + 32'd1;
            if (mem_write && w_sel_tcmp) begin
                r_cmp <= wdata;
                r_irq <= 1'b0;
            end else if (r_count == r_cmp) begin
                r_irq <= 1'b1;
            end
        end
    end

    assign irq = r_irq;

    always_comb begin
        read_data = 32'd0;
        if (w_is_ram) begin
            read_data = r_mem[w_ram_idx];
        end else if (w_sel_ustat) begin
            read_data = {30'd0, r_overrun, w_busy};
        end else if (w_sel_tcount) begin
            read_data = r_count;
        end else if (w_sel_tcmp) begin
            read_data = r_cmp;
        end
    end
`else
    logic [29:0] w_unused_tmr;
    assign w_unused_tmr = c_TMR_COUNT ^ c_TMR_CMP;
    assign irq = 1'b0;

    always_comb begin
        read_data = 32'd0;
        if (w_is_ram) begin
            read_data = r_mem[w_ram_idx];
        end else if (w_sel_ustat) begin
            read_data = {30'd0, r_overrun, w_busy};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio
// Desc     : Directed bench for dmem_mmio (CLK_DIV=4, DEPTH_WORDS=64) with a
//            reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;
    localparam logic [31:0] A_UDATA = 32'hFFFF_0000;
    localparam logic [31:0] A_USTAT = 32'hFFFF_0004;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP  = 32'hFFFF_000C;
    localparam logic [31:0] A_NONE  = 32'h8000_0000;
    localparam int          FRAME   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = A_NONE;
    logic [31:0] wdata = 32'd0;
    logic        mem_write = 1'b0;
    logic [31:0] read_data;
    logic        uart_tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_mmio #(.DEPTH_WORDS(64), .CLK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .read_data (read_data),
        .uart_tx   (uart_tx),
        .irq       (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [64];
    bit          m_known [64];
    bit          m_valid = 1'b0;
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_start = 0;
    logic [7:0]  m_byte = 8'd0;
    bit          m_ovr = 1'b0;
    logic [31:0] m_count = 32'd0;
    logic [31:0] m_cmp = 32'hFFFF_FFFF;
    bit          m_irq = 1'b0;

    function automatic bit m_busy();
        return m_active && ((cyc - m_start) < FRAME);
    endfunction

    // Line level k cycles into a frame: start bit, 8 data bits LSB first, stop bit
    function automatic logic m_tx();
        int k;
        k = cyc - m_start;
        if (!m_busy()) return 1'b1;
        if (k < 4) return 1'b0;
        if (k >= 36) return 1'b1;
        return m_byte[(k / 4) - 1];
    endfunction

    task automatic m_read(input logic [31:0] a, output bit known, output logic [31:0] v);
        known = 1'b1;
        v     = 32'd0;
        if (a[31:28] == 4'h0) begin
            known = m_known[a[7:2]];
            v     = m_mem[a[7:2]];
        end else if (a[31:2] == A_USTAT[31:2]) begin
            v = {30'd0, m_ovr, m_busy()};
`ifdef DMEM_MMIO_TIMER_EN
        end else if (a[31:2] == A_TCNT[31:2]) begin
            v = m_count;
        end else if (a[31:2] == A_TCMP[31:2]) begin
            v = m_cmp;
`endif
        end
    endtask

    always @(posedge clk) begin
        bit busy;
        busy = m_busy();
        if (mem_write && addr[31:28] == 4'h0) begin
            m_mem[addr[7:2]]   = wdata;
            m_known[addr[7:2]] = 1'b1;
        end
        if (!rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_ovr    = 1'b0;
            m_count  = 32'd0;
            m_cmp    = 32'hFFFF_FFFF;
            m_irq    = 1'b0;
        end else begin
            if (mem_write && addr[31:2] == A_UDATA[31:2]) begin
                if (busy) begin
                    m_ovr = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_start  = cyc + 1;
                    m_byte   = wdata[7:0];
                end
            end else if (mem_write && addr[31:2] == A_USTAT[31:2]) begin
                m_ovr = 1'b0;
            end
`ifdef DMEM_MMIO_TIMER_EN
            if (mem_write && addr[31:2] == A_TCMP[31:2]) m_irq = 1'b0;
            else if (m_count == m_cmp) m_irq = 1'b1;
            if (mem_write && addr[31:2] == A_TCMP[31:2]) m_cmp = wdata;
            if (mem_write && addr[31:2] == A_TCNT[31:2]) m_count = wdata;
            else m_count = m_count + 32'd1;
`endif
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit          kn;
        logic [31:0] ev;
        if (m_valid) begin
            chk("model_uart_tx", {31'd0, uart_tx}, {31'd0, m_tx()});
            chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
            m_read(addr, kn, ev);
            if (kn) chk("model_read_data", read_data, ev);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_write = w;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #2;
        mem_write = 1'b0;
        addr      = A_NONE;
        wdata     = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, A_NONE, 32'd0);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        mem_write = 1'b0;
        #1;
        chk(name, read_data, exp);
        @(posedge clk);
        #2;
        addr = A_NONE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq;
        seq = 10'b10_1000_0010;

        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        #1;
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rd_chk(A_USTAT, 32'd0, "reset_stat");

        // RAM round trip, aliasing, ignored low bits, read-before-write
        step(1'b1, 32'h10, 32'hDEAD_BEEF);
        rd_chk(32'h10, 32'hDEAD_BEEF, "ram_rd");
        rd_chk(32'h110, 32'hDEAD_BEEF, "ram_alias");
        rd_chk(32'h13, 32'hDEAD_BEEF, "ram_lowbits");
        addr = 32'h10; mem_write = 1'b1; wdata = 32'h0BAD_F00D;
        #1;
        chk("ram_old_on_write", read_data, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        mem_write = 1'b0;
        rd_chk(32'h10, 32'h0BAD_F00D, "ram_new");

        // UART frame of 0x41
        step(1'b1, A_UDATA, 32'h41);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 4; j++) begin
                addr = A_USTAT;
                #1;
                if (j == 1) chk("frame_bit", {31'd0, uart_tx}, {31'd0, seq[b]});
                if (b == 9 && j == 3) chk("stat_last_cycle", read_data, 32'd1);
                @(posedge clk); #2;
            end
        end
        rd_chk(A_USTAT, 32'd0, "stat_done_at_40");

        // Overrun during a frame, then clear while still busy
        step(1'b1, A_UDATA, 32'h55);
        idle(9);
        step(1'b1, A_UDATA, 32'hAA);
        rd_chk(A_USTAT, 32'd3, "stat_overrun");
        step(1'b1, A_USTAT, 32'd0);
        rd_chk(A_USTAT, 32'd1, "stat_cleared");
        idle(28);
        rd_chk(A_USTAT, 32'd0, "stat_idle_after_ovr");

        // Write in the final STOP cycle is dropped
        step(1'b1, A_UDATA, 32'h0F);
        idle(39);
        step(1'b1, A_UDATA, 32'hF0);
        #1;
        chk("last_stop_tx_idle", {31'd0, uart_tx}, 32'd1);
        rd_chk(A_USTAT, 32'd2, "last_stop_overrun");
        step(1'b1, A_USTAT, 32'h1234);
        rd_chk(A_USTAT, 32'd0, "stat_clear_idle");
        idle(4);

        // Reset mid-frame, then a clean frame
        step(1'b1, A_UDATA, 32'h33);
        idle(15);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        #1;
        chk("abort_tx", {31'd0, uart_tx}, 32'd1);
        rd_chk(A_USTAT, 32'd0, "abort_stat");
        step(1'b1, A_UDATA, 32'h41);
        #1;
        chk("restart_start_bit", {31'd0, uart_tx}, 32'd0);
        idle(40);
        rd_chk(A_USTAT, 32'd0, "restart_done");

`ifdef DMEM_MMIO_TIMER_EN
        step(1'b1, A_TCMP, 32'd20);
        step(1'b1, A_TCNT, 32'd10);
        for (int k = 0; k < 12; k++) begin
            addr = A_TCNT;
            #1;
            chk("tmr_irq_timing", {31'd0, irq}, (k >= 11) ? 32'd1 : 32'd0);
            chk("tmr_count", read_data, 32'(10 + k));
            @(posedge clk); #2;
        end
        step(1'b1, A_TCMP, 32'd5);
        #1;
        chk("tmr_irq_clear", {31'd0, irq}, 32'd0);
        step(1'b1, A_TCNT, 32'hFFFF_FFFF);
        rd_chk(A_TCNT, 32'hFFFF_FFFF, "tmr_max");
        rd_chk(A_TCNT, 32'd0, "tmr_wrap");
`else
        step(1'b1, A_TCNT, 32'd5);
        rd_chk(A_TCNT, 32'd0, "tmr_off_count");
        rd_chk(A_TCMP, 32'd0, "tmr_off_cmp");
        chk("tmr_off_irq", {31'd0, irq}, 32'd0);
`endif

        // Unmapped space
        step(1'b1, 32'h0, 32'h1234_5678);
        step(1'b1, A_NONE, 32'hFFFF);
        rd_chk(A_NONE, 32'd0, "unmapped_rd");
        rd_chk(32'h0, 32'h1234_5678, "unmapped_no_alias");
        rd_chk(A_UDATA, 32'd0, "uart_data_rd");
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
